gpio_bus_arbiter: RTL and testbench
===================================

// Module: gpio_bus_arbiter
// PURPOSE
//  Shares the single GPIO peripheral register port (read/write/address/write_data/read_data)
//  between NUM_REQ bus masters (CPU load/store unit, debug/DMA). Round-robin arbitration,
//  req/ack handshake, optional bus lock for atomic read-modify-write of direction/value regs.
//  Sits between the masters and the GPIO bank; the GPIO bank sees at most one strobe per cycle.
// PARAMETERS
//  NUM_REQ       2    number of requesters, 2..4
//  LOCK_TIMEOUT  64   idle cycles before a held lock is revoked (GPIO_ARB_LOCK_TIMEOUT_EN only)
// PORTS
//  clk          in   1          clock
//  reset        in   1          synchronous, active-high
//  req          in   NUM_REQ    request i pending; hold until ack[i]
//  req_we       in   NUM_REQ    1=write, 0=read, per requester
//  req_lock     in   NUM_REQ    keep ownership after this transfer
//  req_addr     in   32*NUM_REQ flattened, requester i at [32*i+:32]
//  req_wdata    in   32*NUM_REQ flattened write data
//  ack          out  NUM_REQ    one-cycle completion pulse to requester i
//  rdata        out  32         read data, valid in the ack cycle, held until next ack
//  grant        out  NUM_REQ    one-hot current owner, 0 when bus free
//  p_read       out  1          GPIO read strobe
//  p_write      out  1          GPIO write strobe
//  p_address    out  32         GPIO address
//  p_write_data out  32         GPIO write data
//  p_read_data  in   32         GPIO read data (combinational from p_read)
//  lock_timeout out  1          one-cycle pulse on lock revocation
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, ack=0, rdata=0, p_read=p_write=0, p_address=p_write_data=0,
//    lock_timeout=0, rr_ptr=0 (requester 0 highest priority first).
//  - FSM IDLE -> ISSUE -> ACK -> (IDLE | LOCKED).
//  - IDLE: if any req, winner = first set req at or after rr_ptr (wrapping mod NUM_REQ);
//    register winner's we/addr/wdata, grant<=onehot(winner); -> ISSUE. No req: stay.
//  - ISSUE: exactly one cycle of p_read or p_write with registered addr/wdata; on read,
//    rdata<=p_read_data at end of cycle; write leaves rdata unchanged. -> ACK.
//  - ACK: ack[winner]=1 for one cycle; rr_ptr<=winner+1 wrapping. If req_lock[winner] was 1
//    at issue: -> LOCKED, grant held; else grant<=0, -> IDLE.
//  - Latency: req sampled in IDLE cycle N -> strobe cycle N+1 -> ack cycle N+2; next
//    arbitration earliest N+3. Requester must drop or change req in ack cycle.
//  - LOCKED: only owner's req accepted (-> ISSUE directly, no re-arbitration); others wait.
//    Owner req=0 and req_lock=0 -> grant<=0, IDLE. rr_ptr unchanged while locked.
//  - Simultaneous requests: round-robin guarantees each pending requester served within
//    NUM_REQ transfers unless a lock is held.
//  - req deassert before ack (protocol violation): transfer still completes, ack still issued.
//  - Reset mid-transfer: strobe and ack cancelled same edge; no partial ack.
//  - Strobes never overlap; p_read & p_write never both 1.
// CONFIGURATION
//  GPIO_ARB_LOCK_TIMEOUT_EN defined: counter counts LOCKED cycles with owner req=0; at
//   LOCK_TIMEOUT it clears grant, returns to IDLE, pulses lock_timeout 1 cycle; counter
//   clears on any owner req.
//  Not defined: lock held indefinitely; counter absent; lock_timeout tied 0.
// TESTING
//  1. Single read: req=01, addr=0, p_read_data=0x5A -> p_read high cycle 1, ack=01 and
//     rdata=0x5A in cycle 2.
//  2. Write: req[1], we=1, wdata=0x8000_00F0 -> p_write=1, p_write_data=0x8000_00F0 once,
//     ack=10, rdata unchanged.
//  3. Contention: req=11 held continuously from reset -> grants alternate 0,1,0,1; 4 acks.
//  4. Lock: req0 read with lock=1 while req1 pending -> req0's following write issues
//     before req1; req1 served only after req0 drops lock.
//  5. Timeout (macro on, LOCK_TIMEOUT=4): lock held, owner idle 4 cycles -> lock_timeout
//     pulse, grant=0, pending req1 then granted. Macro off: grant held, req1 starved.
//  6. Reset asserted in ISSUE cycle -> no ack, all outputs at reset values next cycle.

Source files
------------

// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - round-robin GPIO register-port arbiter with bus lock
// Optional lock revocation after LOCK_TIMEOUT idle owner cycles: define GPIO_ARB_LOCK_TIMEOUT_EN.
module gpio_bus_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [NUM_REQ-1:0]     req_lock,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     ack,
    output logic [31:0]            rdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   p_read,
    output logic                   p_write,
    output logic [31:0]            p_address,
    output logic [31:0]            p_write_data,
    input  logic [31:0]            p_read_data,
    output logic                   lock_timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_ACK    = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    // Requester indices are 2 bits wide, enough for up to four masters.
    localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 4 || LOCK_TIMEOUT < 1) begin : g_param_check
        $error("gpio_bus_arbiter: NUM_REQ must be 2..4 and LOCK_TIMEOUT at least 1");
    end

    state_t               state_q, state_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [1:0]           owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 we_q, we_d;
    logic                 lock_q, lock_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;

    logic                 arb_found;
    logic [1:0]           arb_idx;
    logic [NUM_REQ-1:0]   arb_onehot;
    logic [1:0]           sel_idx;
    logic                 sel_we;
    logic                 sel_lock;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic                 owner_req;
    logic                 owner_lock;

`ifdef GPIO_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 lock_timeout_q, lock_timeout_d;
`endif

    // Round-robin pick: first pending request at or after rr_ptr, wrapping.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = rr_ptr_q;
        arb_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!arb_found && req[i] && (((int'(rr_ptr_q) + k) % NUM_REQ) == i)) begin
                    arb_found = 1'b1;
                    arb_idx   = 2'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_onehot[i] = (int'(arb_idx) == i);
        end
    end

    // Capture mux: the arbitration winner when idle, the lock owner when locked.
    always_comb begin
        sel_idx   = (state_q == S_LOCKED) ? owner_q : arb_idx;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(sel_idx) == i) begin
                sel_we    = req_we[i];
                sel_lock  = req_lock[i];
                sel_addr  = req_addr[32*i +: 32];
                sel_wdata = req_wdata[32*i +: 32];
            end
        end
        owner_req  = |(req & grant_q);
        owner_lock = |(req_lock & grant_q);
    end

    // Next-state logic: arbitration, single-cycle strobe, ack, lock hold/release.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        we_d     = we_q;
        lock_d   = lock_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef GPIO_ARB_LOCK_TIMEOUT_EN
        cnt_d          = cnt_q;
        lock_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    owner_d = arb_idx;
                    grant_d = arb_onehot;
                    we_d    = sel_we;
                    lock_d  = sel_lock;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!we_q) begin
                    rdata_d = p_read_data;
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                rr_ptr_d = (owner_q == LAST_IDX) ? 2'd0 : owner_q + 2'd1;
                if (lock_q) begin
                    state_d = S_LOCKED;
`ifdef GPIO_ARB_LOCK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (owner_req) begin
                    we_d    = sel_we;
                    lock_d  = sel_lock;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = S_ISSUE;
`ifdef GPIO_ARB_LOCK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (!owner_lock) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
`ifdef GPIO_ARB_LOCK_TIMEOUT_EN
                    if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        grant_d        = '0;
                        state_d        = S_IDLE;
                        lock_timeout_d = 1'b1;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset cancels any strobe or ack in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            we_q     <= 1'b0;
            lock_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            lock_q   <= lock_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef GPIO_ARB_LOCK_TIMEOUT_EN
    // Idle-owner counter and one-cycle revocation pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end
    assign lock_timeout = lock_timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

    // Ack pulses to the owner for the single cycle spent in ACK.
    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (state_q == S_ACK) && (int'(owner_q) == i);
        end
    end

    assign grant        = grant_q;
    assign rdata        = rdata_q;
    assign p_read       = (state_q == S_ISSUE) && !we_q;
    assign p_write      = (state_q == S_ISSUE) && we_q;
    assign p_address    = addr_q;
    assign p_write_data = wdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb/tb_gpio_bus_arbiter.sv - scoreboard bench for gpio_bus_arbiter
module tb_gpio_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req, req_we, req_lock;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  ack, grant;
    logic [31:0] rdata, p_address, p_write_data, p_read_data;
    logic        p_read, p_write, lock_timeout;

    logic [31:0] mem [16];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } strobe_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
    } ack_t;

    strobe_t     sq[$];
    ack_t        aq[$];
    logic [31:0] exp_rdata;

    gpio_bus_arbiter #(
        .NUM_REQ      (2),
        .LOCK_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_we       (req_we),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .rdata        (rdata),
        .grant        (grant),
        .p_read       (p_read),
        .p_write      (p_write),
        .p_address    (p_address),
        .p_write_data (p_write_data),
        .p_read_data  (p_read_data),
        .lock_timeout (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GPIO bank model: reset pattern 0x5A+i, written by p_write.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h5A + 32'(i);
        end else if (p_write) begin
            mem[p_address[3:0]] <= p_write_data;
        end
    end
    assign p_read_data = mem[p_address[3:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic expect_xfer(input int idx, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd);
        strobe_t s;
        ack_t    a;
        s.we = we; s.addr = addr; s.wdata = wdata;
        sq.push_back(s);
        if (!we) exp_rdata = rd;
        a.idx = idx; a.rdata = exp_rdata;
        aq.push_back(a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int i);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ack[i]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL ack_timeout_%0d: ack not seen in 40 cycles, required 1", i);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic lock);
        req_we[i]             = we;
        req_lock[i]           = lock;
        req_addr[32*i +: 32]  = addr;
        req_wdata[32*i +: 32] = wdata;
        req[i]                = 1'b1;
    endtask

    task automatic do_xfer(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic lock, input logic [31:0] rd);
        expect_xfer(i, we, addr, wdata, rd);
        set_req(i, we, addr, wdata, lock);
        wait_ack(i);
        req[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        req_lock = '0;
        tick();
        tick();
        reset     = 1'b0;
        exp_rdata = '0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes the GPIO bank or acks.
    always @(negedge clk) begin
        if (p_read || p_write) begin
            check("strobe_exclusive", 32'(p_read & p_write), 32'd0);
            if (sq.size() == 0) begin
                n_checks++;
                $display("FAIL sb_strobe: got strobe addr %h, required none", p_address);
            end else begin
                strobe_t s;
                s = sq.pop_front();
                check("sb_strobe_we", 32'(p_write), 32'(s.we));
                check("sb_strobe_addr", p_address, s.addr);
                if (s.we) check("sb_strobe_wdata", p_write_data, s.wdata);
            end
        end
        if (ack != 2'b00) begin
            if (aq.size() == 0) begin
                n_checks++;
                $display("FAIL sb_ack: got ack %b, required none", ack);
            end else begin
                ack_t       a;
                logic [1:0] oh;
                a  = aq.pop_front();
                oh = 2'b01 << a.idx;
                check("sb_ack_vec", 32'(ack), 32'(oh));
                check("sb_ack_rdata", rdata, a.rdata);
                check("sb_ack_grant", 32'(grant), 32'(oh));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int n_acks;
        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        exp_rdata = '0;
        reset = 1'b1;
        tick();
        do_reset();

        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_p_read", 32'(p_read), 32'd0);
        check("rst_p_write", 32'(p_write), 32'd0);
        check("rst_p_address", p_address, 32'd0);
        check("rst_p_write_data", p_write_data, 32'd0);
        check("rst_lock_timeout", 32'(lock_timeout), 32'd0);

        // Single read with cycle-exact latency.
        expect_xfer(0, 1'b0, 32'd0, 32'd0, 32'h5A);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        check("t1_p_read_cyc1", 32'(p_read), 32'd1);
        check("t1_grant_cyc1", 32'(grant), 32'd1);
        tick();
        check("t1_ack_cyc2", 32'(ack), 32'd1);
        check("t1_rdata_cyc2", rdata, 32'h5A);
        req[0] = 1'b0;

        // Write from requester 1, then read it back through requester 0.
        do_xfer(1, 1'b1, 32'd4, 32'h8000_00F0, 1'b0, 32'd0);
        check("t2_rdata_held", rdata, 32'h5A);
        do_xfer(0, 1'b0, 32'd4, 32'd0, 1'b0, 32'h8000_00F0);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        expect_xfer(0, 1'b0, 32'd1, 32'd0, 32'h5B);
        expect_xfer(1, 1'b0, 32'd2, 32'd0, 32'h5C);
        expect_xfer(0, 1'b0, 32'd1, 32'd0, 32'h5B);
        expect_xfer(1, 1'b0, 32'd2, 32'd0, 32'h5C);
        set_req(0, 1'b0, 32'd1, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd2, 32'd0, 1'b0);
        n_acks = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ack != 2'b00) n_acks++;
            if (n_acks == 4) begin
                req = '0;
                break;
            end
        end
        check("t3_ack_count", 32'(n_acks), 32'd4);
        tick();

        // Lock: requester 0 keeps the bus for a second transfer while 1 waits.
        set_req(1, 1'b1, 32'd5, 32'h1234_5678, 1'b0);
        do_xfer(0, 1'b0, 32'd3, 32'd0, 1'b1, 32'h5D);
        do_xfer(0, 1'b1, 32'd3, 32'hCAFE_0003, 1'b1, 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("t4_grant_locked", 32'(grant), 32'd1);
            check("t4_req1_waits", 32'(ack[1]), 32'd0);
        end
        expect_xfer(1, 1'b1, 32'd5, 32'h1234_5678, 32'd0);
        req_lock[0] = 1'b0;
        wait_ack(1);
        req[1] = 1'b0;
        tick();

        // Lock held with owner idle: revoked after 4 cycles, or starves requester 1.
        set_req(1, 1'b0, 32'd7, 32'd0, 1'b0);
        do_xfer(0, 1'b0, 32'd6, 32'd0, 1'b1, 32'h60);
`ifdef GPIO_ARB_LOCK_TIMEOUT_EN
        expect_xfer(1, 1'b0, 32'd7, 32'd0, 32'h61);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t5_grant_before_timeout", 32'(grant), 32'd1);
            check("t5_no_pulse_yet", 32'(lock_timeout), 32'd0);
        end
        tick();
        check("t5_timeout_pulse", 32'(lock_timeout), 32'd1);
        check("t5_grant_revoked", 32'(grant), 32'd0);
        wait_ack(1);
        req[1] = 1'b0;
        req_lock[0] = 1'b0;
`else
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t5_grant_held", 32'(grant), 32'd1);
            check("t5_req1_starved", 32'(ack[1]), 32'd0);
            check("t5_no_pulse", 32'(lock_timeout), 32'd0);
        end
        expect_xfer(1, 1'b0, 32'd7, 32'd0, 32'h61);
        req_lock[0] = 1'b0;
        wait_ack(1);
        req[1] = 1'b0;
`endif
        tick();

        // Reset during the strobe cycle: no ack, reset values next cycle.
        begin
            strobe_t s;
            s.we = 1'b0; s.addr = 32'd8; s.wdata = 32'd0;
            sq.push_back(s);
        end
        set_req(0, 1'b0, 32'd8, 32'd0, 1'b0);
        tick();
        check("t6_in_issue", 32'(p_read), 32'd1);
        reset = 1'b1;
        req   = '0;
        tick();
        check("t6_ack", 32'(ack), 32'd0);
        check("t6_grant", 32'(grant), 32'd0);
        check("t6_p_read", 32'(p_read), 32'd0);
        check("t6_p_address", p_address, 32'd0);
        check("t6_rdata", rdata, 32'd0);
        reset     = 1'b0;
        exp_rdata = '0;
        tick();
        tick();
        check("t6_no_late_ack", 32'(ack), 32'd0);

        check("sb_strobe_drained", 32'(sq.size()), 32'd0);
        check("sb_ack_drained", 32'(aq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
